// File: rtl/nml_zone_pipeline.sv
// nml_zone_pipeline: three-phase clocked NML wire stage.
// A 1-bit value captured from the upstream mux is walked through ZONES clock
// zones, one zone per phase step, using internally generated SWITCH/HOLD/RESET
// zone clocking. The far-end zone value is presented with a valid flag.
// Optional build macro: NML_ZONE_STALL_EN adds a `stall` input that freezes the
// phase clocking, the zones and the outputs while high.
module nml_zone_pipeline #(
   parameter int ZONES        = 6,
   parameter int PHASE_CYCLES = 5
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef NML_ZONE_STALL_EN
   input  logic       stall,
`endif
   input  logic       data_in,
   input  logic       in_valid,
   output logic       in_ack,
   output logic       data_out,
   output logic       out_valid,
   output logic [1:0] phase
);

   localparam int             CW       = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
   localparam logic [CW-1:0]  CYC_LAST = CW'(PHASE_CYCLES - 1);

   typedef enum logic [1:0] {
      ZS_SWITCH = 2'd0,
      ZS_HOLD   = 2'd1,
      ZS_RESET  = 2'd2
   } zone_st_e;

   // Local zone state is the global phase delayed by the zone index, mod 3.
   function automatic zone_st_e zone_state(input logic [1:0] ph, input int k);
      logic [1:0] kk;
      logic [1:0] r;
      kk = 2'(k % 3);
      r  = ph - kk;
      if (ph < kk) r = r - 2'd1;   // mod-4 wrap corrected to mod-3
      return zone_st_e'(r);
   endfunction

   logic [CW-1:0]    cyc_cnt_q, cyc_cnt_d;
   logic [1:0]       ph_q, ph_d;
   logic [ZONES-1:0] val_q, val_d;
   logic [ZONES-1:0] vld_q, vld_d;
   logic             ack_q, ack_d;
   logic             stall_w;
   logic             step_w;
   logic [ZONES-1:0] src_val_w;
   logic [ZONES-1:0] src_vld_w;

`ifdef NML_ZONE_STALL_EN
   assign stall_w = stall;
`else
   assign stall_w = 1'b0;
`endif

   // A step edge is the last cycle of a phase; a stalled step is deferred.
   assign step_w = !stall_w && (cyc_cnt_q == CYC_LAST);

   // Source of each zone when it switches: zone 0 takes the input, others the zone behind.
   assign src_val_w = {val_q[ZONES-2:0], data_in};
   assign src_vld_w = {vld_q[ZONES-2:0], in_valid};

   // Next-state: phase counter, phase index, zone transfers and capture acknowledge.
   always_comb begin
      cyc_cnt_d = cyc_cnt_q;
      ph_d      = ph_q;
      val_d     = val_q;
      vld_d     = vld_q;
      ack_d     = 1'b0;
      if (!stall_w) begin
         cyc_cnt_d = step_w ? '0 : cyc_cnt_q + 1'b1;
      end
      if (step_w) begin
         ph_d = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
         for (int k = 0; k < ZONES; k++) begin
            case (zone_state(ph_d, k))
               ZS_SWITCH: begin
                  val_d[k] = src_val_w[k];
                  vld_d[k] = src_vld_w[k];
               end
               ZS_RESET: vld_d[k] = 1'b0;
               default:  ;
            endcase
         end
         ack_d = (ph_d == 2'd0) && in_valid;
      end
   end

   // State registers; async reset discards every in-flight bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt_q <= '0;
         ph_q      <= 2'd2;
         val_q     <= '0;
         vld_q     <= '0;
         ack_q     <= 1'b0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
         ph_q      <= ph_d;
         val_q     <= val_d;
         vld_q     <= vld_d;
         ack_q     <= ack_d;
      end
   end

   assign in_ack    = ack_q && !stall_w;
   assign data_out  = val_q[ZONES-1];
   assign out_valid = vld_q[ZONES-1] && (zone_state(ph_q, ZONES-1) == ZS_HOLD);
   assign phase     = ph_q;

endmodule

// File: tb/tb_nml_zone_pipeline.sv
// Directed bench for nml_zone_pipeline with ZONES=3, PHASE_CYCLES=2.
// Edges are counted from rst_n release; outputs are sampled 1ns after each rising edge.
module tb_nml_zone_pipeline;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       data_in = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ack;
   logic       data_out;
   logic       out_valid;
   logic [1:0] phase;
`ifdef NML_ZONE_STALL_EN
   logic       stall = 1'b0;
`endif

   int n_checks = 0;
   int n_err    = 0;

   nml_zone_pipeline #(.ZONES(3), .PHASE_CYCLES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef NML_ZONE_STALL_EN
      .stall     (stall),
`endif
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ack    (in_ack),
      .data_out  (data_out),
      .out_valid (out_valid),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold reset for 3 clocks, release just after an edge so the next edge is edge 1.
   task automatic apply_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      data_in = 1'b1;
      in_valid = 1'b1;
      repeat (3) tick();
      n_checks++; if (data_out !== 1'b0)  begin n_err++; $display("FAIL reset_data_out got=%b exp=0", data_out); end
      n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (in_ack !== 1'b0)    begin n_err++; $display("FAIL reset_in_ack got=%b exp=0", in_ack); end
      n_checks++; if (phase !== 2'd2)     begin n_err++; $display("FAIL reset_phase got=%0d exp=2", phase); end
      in_valid = 1'b0;
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         logic [1:0] exp_ph;
         tick();
         exp_ph = (e < 2) ? 2'd2 : (e < 4) ? 2'd0 : (e < 6) ? 2'd1 : 2'd2;
         n_checks++;
         if (phase !== exp_ph) begin n_err++; $display("FAIL phase_seq edge=%0d got=%0d exp=%0d", e, phase, exp_ph); end
      end
   endtask

   task automatic test_single_bit();
      data_in = 1'b1;
      in_valid = 1'b1;
      apply_reset();
      for (int e = 1; e <= 16; e++) begin
         logic exp_ack, exp_ov;
         tick();
         if (e == 3) in_valid = 1'b0;
         exp_ack = (e == 2);
         exp_ov  = (e == 8) || (e == 9);
         n_checks++;
         if (in_ack !== exp_ack) begin n_err++; $display("FAIL single_in_ack edge=%0d got=%b exp=%b", e, in_ack, exp_ack); end
         n_checks++;
         if (out_valid !== exp_ov) begin n_err++; $display("FAIL single_out_valid edge=%0d got=%b exp=%b", e, out_valid, exp_ov); end
         if (exp_ov) begin
            n_checks++;
            if (data_out !== 1'b1) begin n_err++; $display("FAIL single_data_out edge=%0d got=%b exp=1", e, data_out); end
         end
      end
   endtask

   task automatic test_stream();
      data_in = 1'b1;
      in_valid = 1'b1;
      apply_reset();
      for (int e = 1; e <= 21; e++) begin
         logic exp_ov, exp_d;
         tick();
         // value for the next capture edge: edge 2 -> 1, edge 8 -> 0, edge 14 -> 1
         data_in = (e < 2) ? 1'b1 : (e < 8) ? 1'b0 : 1'b1;
         exp_ov = (e == 8) || (e == 9) || (e == 14) || (e == 15) || (e == 20) || (e == 21);
         exp_d  = !((e == 14) || (e == 15));
         n_checks++;
         if (out_valid !== exp_ov) begin n_err++; $display("FAIL stream_out_valid edge=%0d got=%b exp=%b", e, out_valid, exp_ov); end
         if (exp_ov) begin
            n_checks++;
            if (data_out !== exp_d) begin n_err++; $display("FAIL stream_data_out edge=%0d got=%b exp=%b", e, data_out, exp_d); end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_invalid_slot();
      data_in = 1'b1;
      in_valid = 1'b0;
      apply_reset();
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_checks++;
         if (in_ack !== 1'b0) begin n_err++; $display("FAIL invalid_in_ack edge=%0d got=%b exp=0", e, in_ack); end
         n_checks++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL invalid_out_valid edge=%0d got=%b exp=0", e, out_valid); end
      end
   endtask

   task automatic test_reset_mid_flight();
      data_in = 1'b1;
      in_valid = 1'b1;
      apply_reset();
      for (int e = 1; e <= 5; e++) begin
         tick();
         if (e == 2) in_valid = 1'b0;
      end
      #4;            // negedge after edge 5
      rst_n = 1'b0;
      #1;
      n_checks++; if (phase !== 2'd2)     begin n_err++; $display("FAIL midrst_phase got=%0d exp=2", phase); end
      n_checks++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (data_out !== 1'b0)  begin n_err++; $display("FAIL midrst_data_out got=%b exp=0", data_out); end
      n_checks++; if (in_ack !== 1'b0)    begin n_err++; $display("FAIL midrst_in_ack got=%b exp=0", in_ack); end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale_out_valid edge=%0d got=%b exp=0", e, out_valid); end
      end
   endtask

`ifdef NML_ZONE_STALL_EN
   task automatic test_stall();
      data_in = 1'b1;
      in_valid = 1'b1;
      stall = 1'b0;
      apply_reset();
      for (int e = 1; e <= 15; e++) begin
         logic [1:0] exp_ph;
         logic       exp_ov, exp_ack;
         tick();
         if (e == 2) in_valid = 1'b0;
         if (e == 3) stall = 1'b1;   // freezes edges 4..7
         if (e == 7) stall = 1'b0;
         exp_ph  = (e < 2) ? 2'd2 : (e < 8) ? 2'd0 : (e < 10) ? 2'd1 : (e < 12) ? 2'd2 : (e < 14) ? 2'd0 : 2'd1;
         exp_ov  = (e == 12) || (e == 13);
         exp_ack = (e == 2);
         n_checks++;
         if (phase !== exp_ph) begin n_err++; $display("FAIL stall_phase edge=%0d got=%0d exp=%0d", e, phase, exp_ph); end
         n_checks++;
         if (out_valid !== exp_ov) begin n_err++; $display("FAIL stall_out_valid edge=%0d got=%b exp=%b", e, out_valid, exp_ov); end
         n_checks++;
         if (in_ack !== exp_ack) begin n_err++; $display("FAIL stall_in_ack edge=%0d got=%b exp=%b", e, in_ack, exp_ack); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_bit();
      test_stream();
      test_invalid_slot();
      test_reset_mid_flight();
`ifdef NML_ZONE_STALL_EN
      test_stall();
`endif
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
